// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: coefficient width, modulus and the coefficient word type
// used by the butterfly, modular and permutation units.
package ntt_pkg;

    localparam int WORD_W = 28;

    // Q = 2^28 - 2^16 + 1
    localparam int unsigned Q = 32'd268369921;

    typedef logic [WORD_W-1:0] coeff_t;

endpackage

// File: rtl/ntt_stride_perm_if.sv
// Streaming pair bus between two NTT butterfly columns: an input pair stream
// and a re-ordered output pair stream with frame markers.
interface ntt_stride_perm_if;
    import ntt_pkg::*;

    logic   in_valid;
    coeff_t in_x;
    coeff_t in_y;

    logic   out_valid;
    coeff_t out_x;
    coeff_t out_y;
    logic   out_first;
    logic   out_last;

    // Upstream/downstream side: drives input pairs, observes the permuted stream.
    modport master (
        output in_valid, in_x, in_y,
        input  out_valid, out_x, out_y, out_first, out_last
    );

    // Permutation buffer side.
    modport slave (
        input  in_valid, in_x, in_y,
        output out_valid, out_x, out_y, out_first, out_last
    );

endinterface

// File: rtl/ntt_perm_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port.
// Storage is never reset; only the read output register clears so an idle
// output reads as zero after reset.
module ntt_perm_ram
    import ntt_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  coeff_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output coeff_t        rd_data
);

    coeff_t mem [DEPTH];
    coeff_t rd_data_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ntt_stride_perm.sv
// Ping-pong stride permutation buffer. Frames of N coefficients arrive as
// consecutive-index pairs (a[2k], a[2k+1]) and leave as (a[i], a[i+DIST]) pairs
// in one gap-free burst per frame. Word idx lives in RAM idx[0]^idx[log2 DIST]
// at address idx>>1, so every write pair and every read pair touches both RAMs
// exactly once.
module ntt_stride_perm
    import ntt_pkg::*;
#(
    parameter int N    = 1024,
    parameter int DIST = 2
) (
    input  logic             clk,
    input  logic             rst,
    ntt_stride_perm_if.slave bus
);

    localparam int LOG_N = $clog2(N);
    localparam int LOG_D = $clog2(DIST);
    localparam int CW    = LOG_N - 1;

    localparam logic [CW-1:0]    LAST_PAIR = CW'(N / 2 - 1);
    localparam logic [CW-1:0]    HALF_DIST = CW'(DIST / 2);
    localparam logic [LOG_N-1:0] LOW_MASK  = LOG_N'(DIST - 1);

    // Insert a zero bit at position log2(DIST): maps output pair number j to
    // the index of its x operand.
    function automatic logic [LOG_N-1:0] insert_zero(input logic [CW-1:0] j);
        logic [LOG_N-1:0] w;
        w = {1'b0, j};
        return ((w >> LOG_D) << (LOG_D + 1)) | (w & LOW_MASK);
    endfunction

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          pend_q, pend_d;
    logic          pend_bank_q, pend_bank_d;
    logic          rd_active_q, rd_active_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;
    logic          swap_q, swap_d;

    logic             wr_wrap;
    logic [LOG_N-1:0] wr_addr;
    coeff_t           ram0_wr_data;
    coeff_t           ram1_wr_data;

    logic             rd_issue;
    logic [CW-1:0]    rd_j;
    logic             rd_sel_bank;
    logic [LOG_N-1:0] rd_idx;
    logic [CW-1:0]    lo_addr;
    logic [CW-1:0]    hi_addr;
    logic [LOG_N-1:0] ram0_rd_addr;
    logic [LOG_N-1:0] ram1_rd_addr;
    coeff_t           ram0_rd_data;
    coeff_t           ram1_rd_data;

    // Write side: count accepted pairs, flip the bank on frame completion and
    // steer each half of the pair to the RAM chosen by its bank-select bit.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        wr_wrap   = 1'b0;
        if (bus.in_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_PAIR) begin
                wr_wrap   = 1'b1;
                wr_bank_d = ~wr_bank_q;
            end
        end
        wr_addr = {wr_bank_q, wr_cnt_q};
        // a[2k] goes to RAM (2k)[log2 DIST] = k[log2 DIST - 1]; a[2k+1] to the other one.
        if (wr_cnt_q[LOG_D-1]) begin
            ram0_wr_data = bus.in_y;
            ram1_wr_data = bus.in_x;
        end else begin
            ram0_wr_data = bus.in_x;
            ram1_wr_data = bus.in_y;
        end
    end

    // Read side: continue an active burst, or start the pending bank's burst
    // the cycle after it became ready; also produce next output flags.
    always_comb begin
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        rd_issue    = 1'b0;
        rd_j        = rd_cnt_q;
        rd_sel_bank = rd_bank_q;

        if (rd_active_q) begin
            rd_issue = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_PAIR) begin
                rd_active_d = 1'b0;
            end
        end else if (pend_q) begin
            rd_issue    = 1'b1;
            rd_j        = '0;
            rd_sel_bank = pend_bank_q;
            rd_bank_d   = pend_bank_q;
            rd_cnt_d    = CW'(1);
            rd_active_d = 1'b1;
            pend_d      = 1'b0;
        end

        if (wr_wrap) begin
            pend_d      = 1'b1;
            pend_bank_d = wr_bank_q;
        end

        // x operand sits in RAM rd_idx[0]; the y operand (bit log2 DIST set)
        // sits in the other RAM, half a distance further along.
        rd_idx  = insert_zero(rd_j);
        lo_addr = rd_idx[LOG_N-1:1];
        hi_addr = rd_idx[LOG_N-1:1] | HALF_DIST;
        if (rd_idx[0]) begin
            ram0_rd_addr = {rd_sel_bank, hi_addr};
            ram1_rd_addr = {rd_sel_bank, lo_addr};
        end else begin
            ram0_rd_addr = {rd_sel_bank, lo_addr};
            ram1_rd_addr = {rd_sel_bank, hi_addr};
        end

        out_valid_d = rd_issue;
        out_first_d = rd_issue && (rd_j == '0);
        out_last_d  = rd_issue && (rd_j == LAST_PAIR);
        swap_d      = rd_issue ? rd_idx[0] : swap_q;
    end

    // Control state and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            swap_q      <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            swap_q      <= swap_d;
        end
    end

    // A ready frame must never find a burst still running (overrun).
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pend_q && rd_active_q))
                else $error("ntt_stride_perm: read start while a burst is active");
        end
    end

    ntt_perm_ram #(.DEPTH(N)) u_ram0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_addr (wr_addr),
        .wr_data (ram0_wr_data),
        .rd_en   (rd_issue),
        .rd_addr (ram0_rd_addr),
        .rd_data (ram0_rd_data)
    );

    ntt_perm_ram #(.DEPTH(N)) u_ram1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_addr (wr_addr),
        .wr_data (ram1_wr_data),
        .rd_en   (rd_issue),
        .rd_addr (ram1_rd_addr),
        .rd_data (ram1_rd_data)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_x     = swap_q ? ram1_rd_data : ram0_rd_data;
    assign bus.out_y     = swap_q ? ram0_rd_data : ram1_rd_data;

endmodule

// File: tb/tb_ntt_stride_perm.sv
// Bench for ntt_stride_perm: three instances (DIST = 4, 8, 2) fed the same
// stream, each checked every cycle against a cycle-scheduled reference model.
module tb_ntt_stride_perm;
    import ntt_pkg::*;

    localparam int N      = 16;
    localparam int NP     = N / 2;
    localparam int ND     = 3;
    localparam int MAXC   = 3000;
    localparam int LOGMAX = 40;

    typedef struct {
        bit     v;
        coeff_t x;
        coeff_t y;
        bit     f;
        bit     l;
    } slot_t;

    typedef struct {
        coeff_t x;
        coeff_t y;
        bit     f;
        bit     l;
        int     cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_stride_perm_if bus4 ();
    ntt_stride_perm_if bus8 ();
    ntt_stride_perm_if bus2 ();

    ntt_stride_perm #(.N(N), .DIST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    ntt_stride_perm #(.N(N), .DIST(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    ntt_stride_perm #(.N(N), .DIST(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic   ov [ND];
    logic   ofs[ND];
    logic   ols[ND];
    coeff_t oxs[ND];
    coeff_t oys[ND];
    assign ov[0] = bus4.out_valid;  assign ov[1] = bus8.out_valid;  assign ov[2] = bus2.out_valid;
    assign ofs[0] = bus4.out_first; assign ofs[1] = bus8.out_first; assign ofs[2] = bus2.out_first;
    assign ols[0] = bus4.out_last;  assign ols[1] = bus8.out_last;  assign ols[2] = bus2.out_last;
    assign oxs[0] = bus4.out_x;     assign oxs[1] = bus8.out_x;     assign oxs[2] = bus2.out_x;
    assign oys[0] = bus4.out_y;     assign oys[1] = bus8.out_y;     assign oys[2] = bus2.out_y;

    int     dist_of [ND] = '{4, 8, 2};
    slot_t  sched [ND][MAXC];
    rec_t   lg [ND][LOGMAX];
    int     lgn [ND];
    coeff_t fr [N];
    coeff_t hx [ND];
    coeff_t hy [ND];
    int     wcnt;
    int     cyc;
    int     rst_cyc;
    int     t_last;
    int     vec;
    int     fails;
    bit     chk_en;

    logic [2*WORD_W+2:0] got_v;
    logic [2*WORD_W+2:0] exp_v;

    // Output pair j of a frame carries a[i], a[i+d]: j's low log2(d) bits stay,
    // the rest moves up one position (blocks of d, skipping every other block).
    function automatic int ins(input int j, input int d);
        return (j / d) * (2 * d) + (j % d);
    endfunction

    // One clock cycle of stimulus plus the reference model's view of it.
    task automatic step(input bit v, input coeff_t x, input coeff_t y, input bit r);
        int i;
        @(posedge clk);
        cyc++;
        #1;
        rst = r;
        bus4.in_valid = v; bus4.in_x = x; bus4.in_y = y;
        bus8.in_valid = v; bus8.in_x = x; bus8.in_y = y;
        bus2.in_valid = v; bus2.in_x = x; bus2.in_y = y;
        if (cyc >= MAXC - NP - 4) begin
            $display("FAIL cycle_budget: at cycle %0d, limit %0d", cyc, MAXC - NP - 4);
            $fatal(1, "cycle budget exhausted");
        end
        if (r) begin
            wcnt    = 0;
            rst_cyc = cyc;
            for (int d = 0; d < ND; d++)
                for (int c = cyc + 1; c < MAXC; c++)
                    sched[d][c].v = 1'b0;
        end else if (v) begin
            fr[2 * wcnt]     = x;
            fr[2 * wcnt + 1] = y;
            wcnt++;
            if (wcnt == NP) begin
                wcnt   = 0;
                t_last = cyc;
                for (int d = 0; d < ND; d++) begin
                    for (int j = 0; j < NP; j++) begin
                        i = ins(j, dist_of[d]);
                        sched[d][cyc + 2 + j].v = 1'b1;
                        sched[d][cyc + 2 + j].x = fr[i];
                        sched[d][cyc + 2 + j].y = fr[i + dist_of[d]];
                        sched[d][cyc + 2 + j].f = (j == 0);
                        sched[d][cyc + 2 + j].l = (j == NP - 1);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, coeff_t'($urandom), coeff_t'($urandom), 1'b0);
    endtask

    task automatic send_frame(input int base, input bit gapped);
        for (int k = 0; k < NP; k++) begin
            step(1'b1, coeff_t'(base + 2 * k), coeff_t'(base + 2 * k + 1), 1'b0);
            if (gapped && k != NP - 1) step(1'b0, coeff_t'($urandom), coeff_t'($urandom), 1'b0);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < ND; d++) lgn[d] = 0;
    endtask

    // Hand-computed expectation against a logged output pair.
    task automatic lit(input string nm, input int d, input int idx, input int ex, input int ey,
                       input bit ef, input bit el, input int ecyc);
        vec++;
        if (idx >= lgn[d]) begin
            fails++;
            $display("FAIL %s[%0d]: only %0d pairs seen, required (%0d,%0d)", nm, idx, lgn[d], ex, ey);
        end else if (lg[d][idx].x !== coeff_t'(ex) || lg[d][idx].y !== coeff_t'(ey) ||
                     lg[d][idx].f !== ef || lg[d][idx].l !== el || lg[d][idx].cyc != ecyc) begin
            fails++;
            $display("FAIL %s[%0d]: got (%0d,%0d) f=%0b l=%0b @%0d, required (%0d,%0d) f=%0b l=%0b @%0d",
                     nm, idx, lg[d][idx].x, lg[d][idx].y, lg[d][idx].f, lg[d][idx].l, lg[d][idx].cyc,
                     ex, ey, ef, el, ecyc);
        end
    endtask

    task automatic chk_count(input string nm, input int d, input int need);
        vec++;
        if (lgn[d] != need) begin
            fails++;
            $display("FAIL %s_count: got %0d valid pairs, required %0d", nm, lgn[d], need);
        end
    endtask

    // Per-cycle comparison of every instance against the model schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                for (int d = 0; d < ND; d++) begin
                    hx[d] = '0;
                    hy[d] = '0;
                end
            end
            for (int d = 0; d < ND; d++) begin
                if (sched[d][cyc].v) begin
                    exp_v = {1'b1, sched[d][cyc].f, sched[d][cyc].l, sched[d][cyc].x, sched[d][cyc].y};
                    hx[d] = sched[d][cyc].x;
                    hy[d] = sched[d][cyc].y;
                end else begin
                    exp_v = {3'b000, hx[d], hy[d]};
                end
                got_v = {ov[d], ofs[d], ols[d], oxs[d], oys[d]};
                vec++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL cyc%0d_dist%0d: got v=%0b f=%0b l=%0b x=%0d y=%0d, required v=%0b f=%0b l=%0b x=%0d y=%0d",
                             cyc, dist_of[d], got_v[2*WORD_W+2], got_v[2*WORD_W+1], got_v[2*WORD_W],
                             got_v[2*WORD_W-1:WORD_W], got_v[WORD_W-1:0],
                             exp_v[2*WORD_W+2], exp_v[2*WORD_W+1], exp_v[2*WORD_W],
                             exp_v[2*WORD_W-1:WORD_W], exp_v[WORD_W-1:0]);
                end
                if (ov[d] === 1'b1 && lgn[d] < LOGMAX) begin
                    lg[d][lgn[d]].x   = oxs[d];
                    lg[d][lgn[d]].y   = oys[d];
                    lg[d][lgn[d]].f   = ofs[d];
                    lg[d][lgn[d]].l   = ols[d];
                    lg[d][lgn[d]].cyc = cyc;
                    lgn[d]++;
                end
            end
        end
    end

    initial begin
        int e4[NP];
        int e8[NP];
        int e2[NP];
        int t1;
        int rk;
        int gap;
        e4 = '{0, 1, 2, 3, 8, 9, 10, 11};
        e8 = '{0, 1, 2, 3, 4, 5, 6, 7};
        e2 = '{0, 1, 4, 5, 8, 9, 12, 13};

        cyc = 0; rst_cyc = -1; vec = 0; fails = 0; chk_en = 1'b0; wcnt = 0; t_last = 0;
        for (int d = 0; d < ND; d++) begin
            hx[d] = '0; hy[d] = '0; lgn[d] = 0;
            for (int c = 0; c < MAXC; c++) sched[d][c].v = 1'b0;
        end
        bus4.in_valid = 1'b0; bus4.in_x = '0; bus4.in_y = '0;
        bus8.in_valid = 1'b0; bus8.in_x = '0; bus8.in_y = '0;
        bus2.in_valid = 1'b0; bus2.in_x = '0; bus2.in_y = '0;

        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk_en = 1'b1;
        idle(3);

        // Single frame a[i]=i, back-to-back pairs.
        clear_logs();
        send_frame(0, 1'b0);
        t1 = t_last;
        idle(12);
        chk_count("s1_d4", 0, NP);
        chk_count("s1_d8", 1, NP);
        chk_count("s1_d2", 2, NP);
        for (int k = 0; k < NP; k++) begin
            lit("s1_d4", 0, k, e4[k], e4[k] + 4, k == 0, k == NP - 1, t1 + 2 + k);
            lit("s1_d8", 1, k, e8[k], e8[k] + 8, k == 0, k == NP - 1, t1 + 2 + k);
            lit("s1_d2", 2, k, e2[k], e2[k] + 2, k == 0, k == NP - 1, t1 + 2 + k);
        end

        // Two frames back-to-back: one contiguous 16-pair stream.
        clear_logs();
        send_frame(0, 1'b0);
        t1 = t_last;
        send_frame(100, 1'b0);
        idle(14);
        chk_count("s2_d4", 0, 2 * NP);
        for (int k = 0; k < 2 * NP; k++) begin
            lit("s2_d4", 0, k, (k < NP) ? e4[k] : 100 + e4[k - NP], ((k < NP) ? e4[k] : 100 + e4[k - NP]) + 4,
                (k % NP) == 0, (k % NP) == NP - 1, t1 + 2 + k);
        end

        // Gapped input: same output, still a contiguous burst.
        clear_logs();
        send_frame(0, 1'b1);
        t1 = t_last;
        idle(12);
        chk_count("s3_d4", 0, NP);
        for (int k = 0; k < NP; k++)
            lit("s3_d4", 0, k, e4[k], e4[k] + 4, k == 0, k == NP - 1, t1 + 2 + k);

        // Reset after three pairs, then a full frame a[i]=50+i.
        clear_logs();
        for (int k = 0; k < 3; k++) step(1'b1, coeff_t'(2 * k), coeff_t'(2 * k + 1), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        send_frame(50, 1'b0);
        t1 = t_last;
        idle(12);
        chk_count("s6_d4", 0, NP);
        lit("s6_d4", 0, 0, 50, 54, 1'b1, 1'b0, t1 + 2);
        lit("s6_d4", 0, NP - 1, 61, 65, 1'b0, 1'b1, t1 + 2 + NP - 1);

        // Reset mid-burst: three pairs out, then silence with zeroed outputs.
        clear_logs();
        send_frame(0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b1);
        idle(12);
        chk_count("s7_d4", 0, 3);
        chk_count("s7_d2", 2, 3);

        // Randomized frames: random data, random gaps, random spacing, one aborted frame.
        for (int f = 0; f < 10; f++) begin
            gap = $urandom_range(0, 2);
            if (f == 6) begin
                rk = $urandom_range(1, NP - 1);
                for (int k = 0; k < rk; k++) step(1'b1, coeff_t'($urandom), coeff_t'($urandom), 1'b0);
                step(1'b0, '0, '0, 1'b1);
            end
            for (int k = 0; k < NP; k++) begin
                while (gap != 0 && $urandom_range(0, 99) < gap * 30)
                    step(1'b0, coeff_t'($urandom), coeff_t'($urandom), 1'b0);
                step(1'b1, coeff_t'($urandom), coeff_t'($urandom), 1'b0);
            end
            idle($urandom_range(0, 2));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
